// File: rtl/sauria_pkg.sv
// sauria_pkg: shared sizes, sequencer state encoding and CTRL/STATUS bit positions
package sauria_pkg;
   localparam int TOTAL_REGS_CON = 2;
   localparam int TOTAL_REGS_ACT = 2;
   localparam int TOTAL_REGS_WEI = 2;
   localparam int TOTAL_REGS_OUT = 2;
   localparam int CFG_WORD_W     = 32;
   localparam int CTRL_START     = 0;
   localparam int CTRL_CLR       = 1;
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_TIMEOUT   = 2;
   typedef enum logic [2:0] {IDLE, COMMIT, START, RUN, DONE} cfg_state_t;
endpackage

// File: rtl/sauria_cfg_shadow_bank.sv
// sauria_cfg_shadow_bank: shadow word array, active copy, write decode and registered read port
module sauria_cfg_shadow_bank
   import sauria_pkg::*;
#(
   parameter int N_TOT  = 8,
   parameter int ADDR_W = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [CFG_WORD_W-1:0]       wr_data,
   output logic                        wr_err,
   input  logic                        rd_en,
   input  logic [ADDR_W-1:0]           rd_addr,
   input  logic [CFG_WORD_W-1:0]       status,
   output logic [CFG_WORD_W-1:0]       rd_data,
   output logic                        rd_valid,
   input  logic                        commit,
   output logic [N_TOT*CFG_WORD_W-1:0] active
);
   logic [CFG_WORD_W-1:0] shadow [N_TOT];
   logic [CFG_WORD_W-1:0] rd_mux;

   // shadow words take software writes in every state
   always_ff @(posedge clk)
      if (!rstn) for (int i = 0; i < N_TOT; i++) shadow[i] <= '0;
      else for (int i = 0; i < N_TOT; i++) if (wr_en && wr_addr == ADDR_W'(i)) shadow[i] <= wr_data;

   // active words snapshot the pre-edge shadow contents during COMMIT only
   always_ff @(posedge clk)
      if (!rstn) active <= '0;
      else if (commit) for (int i = 0; i < N_TOT; i++) active[i*CFG_WORD_W +: CFG_WORD_W] <= shadow[i];

   // read mux: shadow words, STATUS, zero for CTRL and unmapped addresses
   always_comb begin
      rd_mux = (rd_addr == ADDR_W'(N_TOT+1)) ? status : '0;
      for (int i = 0; i < N_TOT; i++) if (rd_addr == ADDR_W'(i)) rd_mux = shadow[i];
   end

   // one-cycle read latency, write error flagged for STATUS and above
   always_ff @(posedge clk)
      if (!rstn) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         wr_err   <= wr_en && (wr_addr > ADDR_W'(N_TOT));
         if (rd_en) rd_data <= rd_mux;
      end
endmodule

// File: rtl/sauria_cfg_sequencer.sv
// sauria_cfg_sequencer: double-buffered config bank with commit/start/run sequencing and watchdog
module sauria_cfg_sequencer
   import sauria_pkg::*;
#(
   parameter int N_CON     = TOTAL_REGS_CON,
   parameter int N_ACT     = TOTAL_REGS_ACT,
   parameter int N_WEI     = TOTAL_REGS_WEI,
   parameter int N_OUT     = TOTAL_REGS_OUT,
   parameter int TIMEOUT_W = 20,
   parameter int ADDR_W    = $clog2(N_CON+N_ACT+N_WEI+N_OUT+2)
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [31:0]         i_wr_data,
   output logic                o_wr_err,
   input  logic                i_rd_en,
   input  logic [ADDR_W-1:0]   i_rd_addr,
   output logic [31:0]         o_rd_data,
   output logic                o_rd_valid,
   output logic [N_CON*32-1:0] o_cfg_con,
   output logic [N_ACT*32-1:0] o_cfg_act,
   output logic [N_WEI*32-1:0] o_cfg_wei,
   output logic [N_OUT*32-1:0] o_cfg_out,
   output logic                o_start,
   input  logic                i_core_done,
   output logic                o_busy,
   output logic                o_irq
);
   localparam int N_TOT = N_CON+N_ACT+N_WEI+N_OUT;
   localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);
   cfg_state_t state_q, state_d;
   logic [TIMEOUT_W-1:0] wd;
   logic [N_TOT*32-1:0] active;
   logic [31:0] status;
   logic timeout_err, ctrl_wr, start_cmd, clr_cmd, expire;

   assign ctrl_wr   = i_wr_en && i_wr_addr == ADDR_W'(N_TOT);
   assign start_cmd = ctrl_wr && i_wr_data[CTRL_START];
   assign clr_cmd   = ctrl_wr && i_wr_data[CTRL_CLR];
   assign expire    = wd == WD_LAST;
   assign o_cfg_con = active[N_CON*32-1:0];
   assign o_cfg_act = active[(N_CON+N_ACT)*32-1 -: N_ACT*32];
   assign o_cfg_wei = active[(N_CON+N_ACT+N_WEI)*32-1 -: N_WEI*32];
   assign o_cfg_out = active[N_TOT*32-1 -: N_OUT*32];

   // state register
   always_ff @(posedge i_clk)
      if (!i_rstn) state_q <= IDLE;
      else state_q <= state_d;

   // next state: start beats clear in DONE, core done beats watchdog expiry in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = start_cmd ? COMMIT : IDLE;
         COMMIT:  state_d = START;
         START:   state_d = RUN;
         RUN:     state_d = (i_core_done || expire) ? DONE : RUN;
         DONE:    state_d = start_cmd ? COMMIT : clr_cmd ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // state-decoded outputs and STATUS word
   always_comb begin
      o_start = state_q == START;
      o_busy  = state_q == COMMIT || state_q == START || state_q == RUN;
      o_irq   = state_q == DONE;
      status  = '0;
      status[STAT_BUSY]    = o_busy;
      status[STAT_DONE]    = o_irq;
      status[STAT_TIMEOUT] = timeout_err;
   end

   // watchdog runs only in RUN; timeout flag is sticky until the next commit
   always_ff @(posedge i_clk)
      if (!i_rstn) begin
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_q == START) wd <= '0;
         else if (state_q == RUN) wd <= wd + 1'b1;
         if (state_q == COMMIT) timeout_err <= 1'b0;
         else if (state_q == RUN && expire && !i_core_done) timeout_err <= 1'b1;
      end

   sauria_cfg_shadow_bank #(.N_TOT(N_TOT), .ADDR_W(ADDR_W)) u_bank (
      .clk      (i_clk),
      .rstn     (i_rstn),
      .wr_en    (i_wr_en),
      .wr_addr  (i_wr_addr),
      .wr_data  (i_wr_data),
      .wr_err   (o_wr_err),
      .rd_en    (i_rd_en),
      .rd_addr  (i_rd_addr),
      .status   (status),
      .rd_data  (o_rd_data),
      .rd_valid (o_rd_valid),
      .commit   (state_q == COMMIT),
      .active   (active)
   );
endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// tb_sauria_cfg_sequencer: directed scenarios with hand-computed expectations
module tb_sauria_cfg_sequencer;
   import sauria_pkg::*;
   localparam int NC = TOTAL_REGS_CON, NA = TOTAL_REGS_ACT, NW = TOTAL_REGS_WEI, NO = TOTAL_REGS_OUT;
   localparam int NT = NC+NA+NW+NO;
   localparam int AW = $clog2(NT+2);
   localparam int CTRL = NT;
   localparam int STAT = NT+1;

   logic clk = 1'b0, rstn = 1'b0, wr_en = 1'b0, rd_en = 1'b0, core_done = 1'b0;
   logic [AW-1:0] wr_addr = '0, rd_addr = '0;
   logic [31:0] wr_data = '0, rd_data, d;
   logic wr_err, rd_valid, start, busy, irq, v;
   logic [NC*32-1:0] cfg_con;
   logic [NA*32-1:0] cfg_act;
   logic [NW*32-1:0] cfg_wei;
   logic [NO*32-1:0] cfg_out;
   int total = 0, bad = 0;

   sauria_cfg_sequencer #(.TIMEOUT_W(4)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_err(wr_err),
      .i_rd_en(rd_en), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
      .o_cfg_con(cfg_con), .o_cfg_act(cfg_act), .o_cfg_wei(cfg_wei), .o_cfg_out(cfg_out),
      .o_start(start), .i_core_done(core_done), .o_busy(busy), .o_irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] x);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = x;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic rd(input int a);
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      rd_en = 1'b0; d = rd_data; v = rd_valid;
   endtask

   task automatic pulse_done();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) tick();
      total++; if ({start, busy, irq, wr_err, rd_valid} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {start, busy, irq, wr_err, rd_valid}); end
      total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
      total++; if ({cfg_con, cfg_act, cfg_wei, cfg_out} !== '0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", {cfg_con, cfg_act, cfg_wei, cfg_out}); end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_shadow_rw();
      wr(0, 32'hDEADBEEF);
      rd(0);
      total++; if (d !== 32'hDEADBEEF || v !== 1'b1) begin bad++; $display("FAIL shadow_read got=%h/%b exp=deadbeef/1", d, v); end
      total++; if (cfg_con[31:0] !== 32'h0) begin bad++; $display("FAIL con_not_committed got=%h exp=0", cfg_con[31:0]); end
      rd(CTRL);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL ctrl_read got=%h exp=0", d); end
      rd(12);
      total++; if (d !== 32'h0 || v !== 1'b1) begin bad++; $display("FAIL oor_read got=%h/%b exp=0/1", d, v); end
   endtask

   task automatic test_start_done();
      wr(CTRL, 32'h1);
      total++; if (busy !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL commit_cycle got=busy%b start%b exp=busy1 start0", busy, start); end
      tick();
      total++; if (start !== 1'b1 || cfg_con[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL start_cycle got=%b/%h exp=1/deadbeef", start, cfg_con[31:0]); end
      tick();
      total++; if (start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL run_entry got=start%b busy%b exp=start0 busy1", start, busy); end
      repeat (7) tick();
      pulse_done();
      total++; if (irq !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL done_irq got=irq%b busy%b exp=irq1 busy0", irq, busy); end
      rd(STAT);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL status_done got=%h exp=2", d); end
      wr(CTRL, 32'h2);
      total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clr_done got=irq%b busy%b exp=0/0", irq, busy); end
   endtask

   task automatic test_run_write();
      wr(CTRL, 32'h1);
      repeat (2) tick();
      wr(NC, 32'h5);
      total++; if (cfg_act[31:0] !== 32'h0) begin bad++; $display("FAIL act_in_run got=%h exp=0", cfg_act[31:0]); end
      wr(CTRL, 32'h1);
      tick();
      total++; if (start !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL start_in_run_ignored got=start%b busy%b exp=start0 busy1", start, busy); end
      pulse_done();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL run_done got=%b exp=1", irq); end
      wr(CTRL, 32'h3);
      total++; if (busy !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL start_wins got=busy%b irq%b exp=busy1 irq0", busy, irq); end
      wr(1, 32'h1111);
      total++; if (cfg_act[31:0] !== 32'h5 || start !== 1'b1) begin bad++; $display("FAIL act_commit got=%h/%b exp=5/1", cfg_act[31:0], start); end
      total++; if (cfg_con[63:32] !== 32'h0) begin bad++; $display("FAIL commit_cycle_write got=%h exp=0", cfg_con[63:32]); end
      tick();
      pulse_done();
      wr(CTRL, 32'h2);
   endtask

   task automatic test_timeout();
      wr(CTRL, 32'h1);
      repeat (16) tick();
      total++; if (busy !== 1'b1 || irq !== 1'b0) begin bad++; $display("FAIL wd_last_run got=busy%b irq%b exp=busy1 irq0", busy, irq); end
      tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL wd_expired got=%b exp=1", irq); end
      rd(STAT);
      total++; if (d !== 32'h6) begin bad++; $display("FAIL status_timeout got=%h exp=6", d); end
      wr(CTRL, 32'h2);
      total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL clr_after_timeout got=irq%b busy%b exp=0/0", irq, busy); end
      rd(STAT);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL timeout_sticky got=%h exp=4", d); end
      wr(CTRL, 32'h1);
      tick();
      rd(STAT);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL timeout_cleared got=%h exp=1", d); end
      pulse_done();
      wr(CTRL, 32'h2);
   endtask

   task automatic test_done_tie();
      wr(CTRL, 32'h1);
      repeat (16) tick();
      pulse_done();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL tie_done got=%b exp=1", irq); end
      rd(STAT);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL tie_status got=%h exp=2", d); end
      wr(CTRL, 32'h2);
   endtask

   task automatic test_wr_err();
      wr(STAT, 32'hFFFF_FFFF);
      total++; if (wr_err !== 1'b1 || busy !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL err_status got=%b%b%b exp=100", wr_err, busy, irq); end
      tick();
      total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL err_pulse_len got=%b exp=0", wr_err); end
      wr(STAT+1, 32'h1);
      total++; if (wr_err !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL err_above got=%b/%b exp=1/0", wr_err, busy); end
      wr(CTRL, 32'h0);
      total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL err_ctrl got=%b exp=0", wr_err); end
      pulse_done();
      total++; if (irq !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL done_in_idle got=irq%b busy%b exp=0/0", irq, busy); end
   endtask

   task automatic test_reset_in_run();
      wr(CTRL, 32'h1);
      tick();
      rd(0);
      rstn = 1'b0;
      tick();
      total++; if ({start, busy, irq, wr_err, rd_valid} !== 5'b0) begin bad++; $display("FAIL rst_run_flags got=%b exp=00000", {start, busy, irq, wr_err, rd_valid}); end
      total++; if (rd_data !== 32'h0 || cfg_con !== '0) begin bad++; $display("FAIL rst_run_data got=%h/%h exp=0/0", rd_data, cfg_con); end
      rstn = 1'b1;
      repeat (2) begin
         tick();
         total++; if (start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_no_start got=start%b busy%b exp=0/0", start, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_shadow_rw();
      test_start_done();
      test_run_write();
      test_timeout();
      test_done_tie();
      test_wr_err();
      test_reset_in_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
